// File: rtl/panel_controller.sv
// Front-panel controller: multiplexes 8 LEDs over 4 blanked column drivers and
// debounces the four active-low panel buttons into run-control state for the core.
module panel_controller #(
  parameter int COLUMN_TICKS     = 4096,
  parameter int BLANK_TICKS      = 256,
  parameter int SAMPLE_TICKS     = 65536,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic [31:0] display_data,
  output logic [7:0]  leds,
  output logic [3:0]  column,
  input  logic        button_reset_n,
  input  logic        button_halt_n,
  input  logic        button_program_select_n,
  input  logic        button_0_n,
  output logic [3:0]  buttons_level,
  output logic [3:0]  buttons_pressed,
  output logic        cpu_reset,
  output logic        halted,
  output logic [1:0]  program_select,
  output logic [2:0]  dbg_scan_o
);

  localparam int MAX_TICKS = (COLUMN_TICKS > BLANK_TICKS) ? COLUMN_TICKS : BLANK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int PRE_W     = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(COLUMN_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SAMPLE_TICKS - 1);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} scan_state_e;

  scan_state_e      state_q, state_d;
  logic [1:0]       col_q, col_d, col_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [3:0]       column_q, column_d;
  logic [7:0]       leds_q, leds_d;

  assign col_inc = col_q + 2'd1;

  // start_q marks the SHOW entry for column 0 that follows reset release.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    column_d = column_q;
    leds_d   = leds_q;
    if (start_q) begin
      start_d  = 1'b0;
      column_d = ~(4'b0001 << col_q);
      leds_d   = display_data[{col_q, 3'b000} +: 8];
    end else begin
      case (state_q)
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d  = BLANK;
            cnt_d    = '0;
            column_d = 4'b1111;
            leds_d   = 8'h00;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d  = SHOW;
            cnt_d    = '0;
            col_d    = col_inc;
            column_d = ~(4'b0001 << col_inc);
            leds_d   = display_data[{col_inc, 3'b000} +: 8];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SHOW;
      endcase
    end
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q  <= SHOW;
      col_q    <= 2'd0;
      cnt_q    <= '0;
      start_q  <= 1'b1;
      column_q <= 4'b1111;
      leds_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      column_q <= column_d;
      leds_q   <= leds_d;
    end
  end

  // Bit order everywhere: {button_0, program_select, halt, reset}.
  logic [3:0]                  pins_n;
  logic [3:0]                  sync1_q, sync2_q, btn;
  logic [PRE_W-1:0]            pre_q, pre_d;
  logic                        sample_tick;
  logic [DEBOUNCE_SAMPLES-1:0] hist_q [4];
  logic [DEBOUNCE_SAMPLES-1:0] hist_d [4];
  logic [3:0]                  level_q, level_d, pressed_q, pressed_d;
  logic                        halted_q, halted_d;
  logic [1:0]                  prog_q, prog_d;

  assign pins_n      = {button_0_n, button_program_select_n, button_halt_n, button_reset_n};
  assign btn         = ~sync2_q;
  assign sample_tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d   = sample_tick ? '0 : pre_q + PRE_W'(1);
    hist_d  = hist_q;
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      if (sample_tick) hist_d[i] = {hist_q[i][DEBOUNCE_SAMPLES-2:0], btn[i]};
      if ((&hist_q[i]) && !level_q[i]) level_d[i] = 1'b1;
      else if ((~|hist_q[i]) && level_q[i]) level_d[i] = 1'b0;
    end
    pressed_d = level_d & ~level_q;
  end

  // A reset-button press overrides a simultaneous halt toggle.
  always_comb begin
    halted_d = halted_q;
    prog_d   = prog_q;
    if (pressed_q[0]) halted_d = 1'b0;
    else if (pressed_q[1]) halted_d = ~halted_q;
    if (pressed_q[2]) prog_d = prog_q + 2'd1;
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 4'b1111;
      sync2_q   <= 4'b1111;
      pre_q     <= '0;
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      level_q   <= 4'b0000;
      pressed_q <= 4'b0000;
      halted_q  <= 1'b0;
      prog_q    <= 2'd0;
    end else begin
      sync1_q   <= pins_n;
      sync2_q   <= sync1_q;
      pre_q     <= pre_d;
      hist_q    <= hist_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      halted_q  <= halted_d;
      prog_q    <= prog_d;
    end
  end

  assign leds            = leds_q;
  assign column          = column_q;
  assign buttons_level   = level_q;
  assign buttons_pressed = pressed_q;
  assign halted          = halted_q;
  assign program_select  = prog_q;
  assign cpu_reset       = reset | level_q[0];
  assign dbg_scan_o      = {state_q, col_q};

endmodule

// File: tb/tb_panel_controller.sv
// Randomized and directed bench for panel_controller against a timeline-based
// reference model of the scan sequence and button debounce rules.
module tb_panel_controller;
  localparam int C   = 4;
  localparam int B   = 2;
  localparam int ST  = 3;
  localparam int DS  = 3;
  localparam int PER = C + B;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [3:0]  pins;
  logic [7:0]  leds;
  logic [3:0]  column, level, pressed;
  logic        cpu_reset, halted;
  logic [1:0]  prog;
  logic [2:0]  dbg_scan;

  always #5 clk = ~clk;

  panel_controller #(
    .COLUMN_TICKS(C), .BLANK_TICKS(B), .SAMPLE_TICKS(ST), .DEBOUNCE_SAMPLES(DS)
  ) dut (
    .raw_clk(clk), .reset(rst), .display_data(data), .leds(leds), .column(column),
    .button_reset_n(pins[0]), .button_halt_n(pins[1]),
    .button_program_select_n(pins[2]), .button_0_n(pins[3]),
    .buttons_level(level), .buttons_pressed(pressed), .cpu_reset(cpu_reset),
    .halted(halted), .program_select(prog), .dbg_scan_o(dbg_scan)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: n counts clock edges since reset release.
  int         n;
  logic [7:0] m_leds;
  logic [3:0] m_level, m_pressed, m_flip, run_val, p1, p2;
  int         run_len [4];
  logic       m_halted;
  logic [1:0] m_prog;

  task automatic reset_model();
    n = 0; m_leds = 8'h00; m_level = '0; m_pressed = '0; m_flip = '0;
    run_val = '0; p1 = 4'hF; p2 = 4'hF; m_halted = 1'b0; m_prog = 2'd0;
    for (int i = 0; i < 4; i++) run_len[i] = DS;
  endtask

  task automatic check_reset_values();
    chk("rst_column", 32'(column), 32'hF);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_pressed", 32'(pressed), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_prog", 32'(prog), 32'h0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
    chk("rst_dbg_scan", 32'(dbg_scan), 32'h0);
  endtask

  task automatic step();
    logic [3:0]  pins_pre;
    logic [31:0] data_pre;
    logic [3:0]  one;
    logic [3:0]  exp_col;
    logic [7:0]  exp_leds;
    logic        s;
    int          p, col, r;
    bit          show;
    pins_pre = pins;
    data_pre = data;
    @(posedge clk);
    #1;
    n++;
    // run control acts on the pulses visible during the previous cycle
    if (m_pressed[0]) m_halted = 1'b0;
    else if (m_pressed[1]) m_halted = ~m_halted;
    if (m_pressed[2]) m_prog = m_prog + 2'd1;
    for (int i = 0; i < 4; i++) begin
      if (m_flip[i]) begin
        m_level[i]   = ~m_level[i];
        m_pressed[i] = m_level[i];
      end else begin
        m_pressed[i] = 1'b0;
      end
    end
    m_flip = '0;
    if (n % ST == 0) begin
      for (int i = 0; i < 4; i++) begin
        s = ~p2[i];
        if (s == run_val[i]) begin
          if (run_len[i] < DS) run_len[i]++;
        end else begin
          run_val[i] = s;
          run_len[i] = 1;
        end
        m_flip[i] = (run_len[i] >= DS) && (run_val[i] != m_level[i]);
      end
    end
    p2 = p1;
    p1 = pins_pre;
    p    = (n - 1) % (4 * PER);
    col  = p / PER;
    r    = p % PER;
    show = (r < C);
    if (show && r == 0) m_leds = data_pre[8*col +: 8];
    one      = 4'b0001;
    exp_col  = show ? ~(one << col) : 4'hF;
    exp_leds = show ? m_leds : 8'h00;
    chk("column", 32'(column), 32'(exp_col));
    chk("leds", 32'(leds), 32'(exp_leds));
    chk("dbg_scan", 32'(dbg_scan), 32'({~show, 2'(col)}));
    chk("level", 32'(level), 32'(m_level));
    chk("pressed", 32'(pressed), 32'(m_pressed));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("prog", 32'(prog), 32'(m_prog));
    chk("cpu_reset", 32'(cpu_reset), 32'(m_level[0]));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic press(input int idx, input int hold, input int idle);
    pins[idx] = 1'b0;
    run(hold);
    pins[idx] = 1'b1;
    run(idle);
  endtask

  initial begin
    int lat, pulses, seen, hold [4];
    rst  = 1'b1;
    pins = 4'hF;
    data = 32'hA1B2C3D4;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    reset_model();

    // scan sequence, with a mid-SHOW data change during column 1
    for (int i = 0; i < 30; i++) begin
      if (n == 8) data = $urandom;
      step();
      if (n == 10) chk("col1_byte_held", 32'(leds), 32'hC3);
      if (n == 13) chk("col2_new_byte", 32'(leds), 32'(data[23:16]));
    end

    // halt press: bounded latency, single pulse, toggle
    pins[1] = 1'b0;
    lat = -1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (lat < 0 && level[1]) lat = i + 1;
      pulses += int'(pressed[1]);
    end
    pins[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(pressed[1]);
    end
    chk("halt_latency_ok", 32'(lat > 0 && lat <= 3 + DS * ST), 32'h1);
    chk("halt_pulse_count", 32'(pulses), 32'h1);
    chk("halted_set", 32'(halted), 32'h1);
    press(1, 20, 20);
    chk("halted_cleared", 32'(halted), 32'h0);

    // bounce shorter than the debounce window
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      pins[1] = ~pins[1];
      for (int j = 0; j < 4; j++) begin
        step();
        seen |= int'(level[1]);
      end
    end
    pins[1] = 1'b1;
    run(15);
    chk("bounce_no_level", 32'(seen), 32'h0);
    chk("bounce_halted", 32'(halted), 32'h0);

    for (int k = 1; k <= 4; k++) begin
      press(2, 15, 15);
      chk("prog_seq", 32'(prog), 32'(k % 4));
    end

    // reset button while halted
    press(1, 15, 15);
    chk("halted_before_rst_btn", 32'(halted), 32'h1);
    pins[0] = 1'b0;
    run(15);
    chk("cpu_reset_held", 32'(cpu_reset), 32'h1);
    chk("rst_btn_clears_halt", 32'(halted), 32'h0);
    pins[0] = 1'b1;
    run(15);

    // reset pin asserted mid-debounce of the halt button
    pins[1] = 1'b0;
    run(6);
    rst = 1'b1;
    #1;
    check_reset_values();
    pins[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    reset_model();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(pressed != 4'b0000);
    end
    chk("no_pulse_after_reset", 32'(pulses), 32'h0);

    // randomized buttons and display data
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          pins[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 14);
        end
      end
      if ($urandom_range(0, 15) == 0) data = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
